// File: rtl/memory_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_if
// Description : Data-memory bus between the memory stage and the memory
//               system. The stage is the master; it drives a request with a
//               word-aligned address, lane-replicated write data and byte
//               strobes. The memory answers with gnt (request accepted) and
//               rvalid (read data / store response).
//               mem_error exists only when MEM_ACCESS_FAULT_EN is defined.
// Signals     : mem_req, mem_we, mem_address[31:0], mem_wdata[31:0],
//               mem_wstrb[3:0]                      master -> slave
//               mem_gnt, mem_rvalid, mem_rdata[31:0],
//               mem_error (optional)                slave  -> master
// Revision    : 1.0  initial release
// ============================================================================
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef MEM_ACCESS_FAULT_EN
  logic        mem_error;

  modport master (
    output mem_req, mem_we, mem_address, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_error
  );
  modport slave (
    input  mem_req, mem_we, mem_address, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata, mem_error
  );
`else
  modport master (
    output mem_req, mem_we, mem_address, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_address, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
`endif
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline stage between execute and writeback. Issues data
//               loads/stores over a req/gnt/rvalid bus, aligns and extends
//               load data, flags misaligned accesses, and registers every
//               field that writeback consumes.
// Parameters  : STORE_WAIT_RESP  0: a store completes on gnt
//                                1: a store completes on rvalid
// Macro       : MEM_ACCESS_FAULT_EN  adds mem_error on the bus; a faulting
//               access completes with ecause 5 (load) / 7 (store).
// Ports       : clk, reset           clock, synchronous active-high reset
//               *_in                 instruction slot from execute
//               stall, invalidate    hazard control (hold / flush)
//               busy                 stage cannot accept a new instruction
//               mem_bus              memory_stage_if master
//               *_out                pipeline register towards writeback
// Revision    : 1.0  initial release
// ============================================================================
module memory_stage #(
  parameter bit STORE_WAIT_RESP = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   next_pc_in,
  input  logic [31:0]   alu_data_in,
  input  logic [31:0]   csr_data_in,
  input  logic [31:0]   store_data_in,
  input  logic [1:0]    write_select_in,
  input  logic [4:0]    rd_address_in,
  input  logic [11:0]   csr_address_in,
  input  logic          csr_write_in,
  input  logic          mret_in,
  input  logic          wfi_in,
  input  logic          load_in,
  input  logic          store_in,
  input  logic          load_signed_in,
  input  logic [1:0]    load_store_size_in,
  input  logic          valid_in,
  input  logic          exception_in,
  input  logic [3:0]    ecause_in,
  input  logic          stall,
  input  logic          invalidate,
  output logic          busy,
  memory_stage_if.master mem_bus,
  output logic [31:0]   pc_out,
  output logic [31:0]   next_pc_out,
  output logic [31:0]   alu_data_out,
  output logic [31:0]   csr_data_out,
  output logic [31:0]   load_data_out,
  output logic [1:0]    write_select_out,
  output logic [4:0]    rd_address_out,
  output logic [11:0]   csr_address_out,
  output logic          csr_write_out,
  output logic          mret_out,
  output logic          wfi_out,
  output logic          valid_out,
  output logic          exception_out,
  output logic [3:0]    ecause_out
);

  localparam logic [3:0] c_ECAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] c_ECAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] c_ECAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] c_ECAUSE_STORE_FAULT      = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // Request captured at issue so the bus stays stable in REQ regardless of
  // what upstream does after a flush.
  logic [31:0] r_address;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic        r_is_load;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;

  logic        r_discard;     // in-flight op was flushed; drop its completion
  logic        r_buf_valid;   // completion arrived under stall, not yet shown
  logic [31:0] r_buf_data;
  logic        r_buf_err;

  logic [31:0] r_pc_out, r_next_pc_out, r_alu_data_out, r_csr_data_out;
  logic [31:0] r_load_data_out;
  logic [1:0]  r_write_select_out;
  logic [4:0]  r_rd_address_out;
  logic [11:0] r_csr_address_out;
  logic        r_csr_write_out, r_mret_out, r_wfi_out;
  logic        r_valid_out, r_exception_out;
  logic [3:0]  r_ecause_out;

  logic        w_mem_op, w_aligned, w_misaligned, w_issue;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_bus_error;
  logic        w_complete, w_comp_err, w_cur_is_load;
  logic [31:0] w_rdata_shifted, w_load_data, w_comp_data;
  logic        w_present, w_pres_err, w_pres_load;
  logic [31:0] w_pres_data;

`ifdef MEM_ACCESS_FAULT_EN
  assign w_bus_error = mem_bus.mem_error;
`else
  assign w_bus_error = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Decode of the incoming slot
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_op = valid_in && !exception_in && (load_in || store_in);
    case (load_store_size_in)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = !alu_data_in[0];
      default: w_aligned = (alu_data_in[1:0] == 2'b00);
    endcase
    w_misaligned = w_mem_op && !w_aligned;
    w_issue = (r_state == S_IDLE) && w_mem_op && w_aligned &&
              !stall && !invalidate && !r_buf_valid;

    case (load_store_size_in)
      2'b00: begin
        w_wdata = {4{store_data_in[7:0]}};
        w_wstrb = 4'b0001 << alu_data_in[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data_in[15:0]}};
        w_wstrb = 4'b0011 << alu_data_in[1:0];
      end
      default: begin
        w_wdata = store_data_in;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Issue cycle drives the bus straight from the inputs; REQ replays the
  // captured request until it is granted.
  assign mem_bus.mem_req     = w_issue || (r_state == S_REQ);
  assign mem_bus.mem_address = (r_state == S_REQ) ? r_address
                                                  : {alu_data_in[31:2], 2'b00};
  assign mem_bus.mem_wdata   = (r_state == S_REQ) ? r_wdata : w_wdata;
  assign mem_bus.mem_wstrb   = (r_state == S_REQ) ? r_wstrb : w_wstrb;
  assign mem_bus.mem_we      = (r_state == S_REQ) ? r_we    : store_in;

  // --------------------------------------------------------------------------
  // Load data alignment (half accesses are even, so the byte shift also
  // selects the right half)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rdata_shifted = mem_bus.mem_rdata >> {r_addr_lo, 3'b000};
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed && w_rdata_shifted[7]}},
                              w_rdata_shifted[7:0]};
      2'b01:   w_load_data = {{16{r_signed && w_rdata_shifted[15]}},
                              w_rdata_shifted[15:0]};
      default: w_load_data = w_rdata_shifted;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM next state and completion detection
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_complete   = 1'b0;
    w_comp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          if (mem_bus.mem_gnt) begin
            if (load_in || STORE_WAIT_RESP) begin
              w_next_state = S_RESP;
            end else begin
              w_complete = 1'b1;
              w_comp_err = w_bus_error;
            end
          end else begin
            w_next_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_bus.mem_gnt) begin
          if (r_is_load || STORE_WAIT_RESP) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_IDLE;
            w_complete   = 1'b1;
            w_comp_err   = w_bus_error;
          end
        end
      end
      S_RESP: begin
        if (mem_bus.mem_rvalid) begin
          w_next_state = S_IDLE;
          w_complete   = 1'b1;
          w_comp_err   = w_bus_error;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    // Only loads carry data, and loads always finish in RESP.
    w_comp_data   = (r_state == S_RESP && r_is_load && !w_comp_err) ? w_load_data
                                                                     : 32'd0;
    w_cur_is_load = (r_state == S_IDLE) ? load_in : r_is_load;
    // A completion reaches writeback now, either live or from the buffer.
    w_present     = !invalidate && !stall &&
                    (r_buf_valid || (w_complete && !r_discard));
    w_pres_err    = r_buf_valid ? r_buf_err  : w_comp_err;
    w_pres_data   = r_buf_valid ? r_buf_data : w_comp_data;
    w_pres_load   = r_buf_valid ? r_is_load  : w_cur_is_load;
    // Busy drops in the cycle the result is presented so upstream advances
    // on that same edge and the op is not reissued.
    busy = !w_present && ((r_state != S_IDLE) || r_buf_valid || w_issue);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture, discard/buffer flags and the writeback register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_address          <= 32'd0;
      r_wdata            <= 32'd0;
      r_wstrb            <= 4'd0;
      r_we               <= 1'b0;
      r_is_load          <= 1'b0;
      r_signed           <= 1'b0;
      r_size             <= 2'd0;
      r_addr_lo          <= 2'd0;
      r_discard          <= 1'b0;
      r_buf_valid        <= 1'b0;
      r_buf_data         <= 32'd0;
      r_buf_err          <= 1'b0;
      r_pc_out           <= 32'd0;
      r_next_pc_out      <= 32'd0;
      r_alu_data_out     <= 32'd0;
      r_csr_data_out     <= 32'd0;
      r_load_data_out    <= 32'd0;
      r_write_select_out <= 2'd0;
      r_rd_address_out   <= 5'd0;
      r_csr_address_out  <= 12'd0;
      r_csr_write_out    <= 1'b0;
      r_mret_out         <= 1'b0;
      r_wfi_out          <= 1'b0;
      r_valid_out        <= 1'b0;
      r_exception_out    <= 1'b0;
      r_ecause_out       <= 4'd0;
    end else begin
      if (w_issue) begin
        r_address <= {alu_data_in[31:2], 2'b00};
        r_wdata   <= w_wdata;
        r_wstrb   <= w_wstrb;
        r_we      <= store_in;
        r_is_load <= load_in;
        r_signed  <= load_signed_in;
        r_size    <= load_store_size_in;
        r_addr_lo <= alu_data_in[1:0];
      end

      if (w_complete) begin
        r_discard <= 1'b0;
      end else if (invalidate && (r_state != S_IDLE)) begin
        r_discard <= 1'b1;
      end

      if (invalidate || w_present) begin
        r_buf_valid <= 1'b0;
      end else if (w_complete && !r_discard && stall) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= w_comp_data;
        r_buf_err   <= w_comp_err;
      end

      if (invalidate) begin
        r_valid_out <= 1'b0;
      end else if (!stall) begin
        if (w_present || !busy) begin
          r_pc_out           <= pc_in;
          r_next_pc_out      <= next_pc_in;
          r_alu_data_out     <= alu_data_in;
          r_csr_data_out     <= csr_data_in;
          r_write_select_out <= write_select_in;
          r_rd_address_out   <= rd_address_in;
          r_csr_address_out  <= csr_address_in;
          r_csr_write_out    <= csr_write_in;
          r_mret_out         <= mret_in;
          r_wfi_out          <= wfi_in;
        end
        if (w_present) begin
          r_valid_out     <= 1'b1;
          r_exception_out <= w_pres_err;
          r_ecause_out    <= w_pres_err ? (w_pres_load ? c_ECAUSE_LOAD_FAULT
                                                       : c_ECAUSE_STORE_FAULT)
                                        : ecause_in;
          r_load_data_out <= w_pres_data;
        end else if (busy) begin
          r_valid_out <= 1'b0;
        end else begin
          r_valid_out     <= valid_in;
          r_exception_out <= exception_in || w_misaligned;
          r_ecause_out    <= w_misaligned ? (load_in ? c_ECAUSE_LOAD_MISALIGNED
                                                     : c_ECAUSE_STORE_MISALIGNED)
                                          : ecause_in;
          r_load_data_out <= 32'd0;
        end
      end
    end
  end

  assign pc_out           = r_pc_out;
  assign next_pc_out      = r_next_pc_out;
  assign alu_data_out     = r_alu_data_out;
  assign csr_data_out     = r_csr_data_out;
  assign load_data_out    = r_load_data_out;
  assign write_select_out = r_write_select_out;
  assign rd_address_out   = r_rd_address_out;
  assign csr_address_out  = r_csr_address_out;
  assign csr_write_out    = r_csr_write_out;
  assign mret_out         = r_mret_out;
  assign wfi_out          = r_wfi_out;
  assign valid_out        = r_valid_out;
  assign exception_out    = r_exception_out;
  assign ecause_out       = r_ecause_out;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Self-checking bench for memory_stage. Directed scenarios for
//               reset, ALU pass-through, loads, stores, misalignment,
//               flush and stall, followed by randomized instructions with a
//               randomly timed memory. Expected values come from a
//               byte-level reference model of the load/store rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_memory_stage;

  localparam bit c_STORE_WAIT_RESP = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, csr_data_in, store_data_in;
  logic [1:0]  write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        csr_write_in, mret_in, wfi_in;
  logic        load_in, store_in, load_signed_in;
  logic [1:0]  load_store_size_in;
  logic        valid_in, exception_in;
  logic [3:0]  ecause_in;
  logic        stall, invalidate;
  logic        busy;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_address_out;
  logic [11:0] csr_address_out;
  logic        csr_write_out, mret_out, wfi_out;
  logic        valid_out, exception_out;
  logic [3:0]  ecause_out;

  memory_stage_if bus();

  memory_stage #(.STORE_WAIT_RESP(c_STORE_WAIT_RESP)) dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .csr_data_in(csr_data_in), .store_data_in(store_data_in),
    .write_select_in(write_select_in), .rd_address_in(rd_address_in),
    .csr_address_in(csr_address_in), .csr_write_in(csr_write_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .load_in(load_in), .store_in(store_in),
    .load_signed_in(load_signed_in), .load_store_size_in(load_store_size_in),
    .valid_in(valid_in), .exception_in(exception_in), .ecause_in(ecause_in),
    .stall(stall), .invalidate(invalidate), .busy(busy), .mem_bus(bus),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .load_data_out(load_data_out),
    .write_select_out(write_select_out), .rd_address_out(rd_address_out),
    .csr_address_out(csr_address_out), .csr_write_out(csr_write_out),
    .mret_out(mret_out), .wfi_out(wfi_out), .valid_out(valid_out),
    .exception_out(exception_out), .ecause_out(ecause_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned size_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_aligned(input logic [31:0] addr, input logic [1:0] size);
    return (addr % size_bytes(size)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input bit sgn);
    longint unsigned n    = size_bytes(size);
    longint unsigned off  = addr % 4;
    longint unsigned span = 64'd1 << (8 * n);
    longint unsigned v    = (longint'(rdata) >> (8 * off)) % span;
    if (sgn && v >= span / 2) v = v + (64'd1 << 32) - span;
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] sdata, output logic [3:0] strb,
                             output logic [31:0] wdata);
    int unsigned n   = size_bytes(size);
    int unsigned off = addr % 4;
    strb  = 4'd0;
    wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      strb[i] = (i >= off) && (i < off + n);
      wdata   = wdata | (((sdata >> (8 * (i % n))) & 32'hFF) << (8 * i));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  typedef struct packed {
    logic [31:0] pc, next_pc, alu, csr;
    logic [1:0]  ws;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic        csr_wr, mret, wfi;
  } fields_t;

  function automatic fields_t snap();
    fields_t f;
    f.pc = pc_in; f.next_pc = next_pc_in; f.alu = alu_data_in; f.csr = csr_data_in;
    f.ws = write_select_in; f.rd = rd_address_in; f.csr_addr = csr_address_in;
    f.csr_wr = csr_write_in; f.mret = mret_in; f.wfi = wfi_in;
    return f;
  endfunction

  task automatic check_fields(input string tag, input fields_t e);
    check_value({tag, ".pc"}, pc_out, e.pc);
    check_value({tag, ".next_pc"}, next_pc_out, e.next_pc);
    check_value({tag, ".alu"}, alu_data_out, e.alu);
    check_value({tag, ".csr"}, csr_data_out, e.csr);
    check_value({tag, ".ctl"},
                {10'd0, write_select_out, rd_address_out, csr_address_out,
                 csr_write_out, mret_out, wfi_out},
                {10'd0, e.ws, e.rd, e.csr_addr, e.csr_wr, e.mret, e.wfi});
  endtask

  task automatic randomize_fields();
    pc_in = $urandom; next_pc_in = $urandom; alu_data_in = $urandom;
    csr_data_in = $urandom; store_data_in = $urandom;
    write_select_in = 2'($urandom); rd_address_in = 5'($urandom);
    csr_address_in = 12'($urandom); csr_write_in = 1'($urandom);
    mret_in = 1'($urandom); wfi_in = 1'($urandom); ecause_in = 4'($urandom);
    load_signed_in = 1'($urandom); load_store_size_in = 2'($urandom_range(0, 2));
  endtask

  task automatic go_idle();
    valid_in = 1'b0; exception_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
    randomize_fields();
  endtask

  // Non-memory slot (ALU, exception pass-through, or invalid bubble).
  task automatic run_plain(input bit v, input bit exc, input bit ld, input bit st,
                           input string tag);
    fields_t e;
    logic [3:0] ec;
    @(posedge clk); #1;
    randomize_fields();
    valid_in = v; exception_in = exc; load_in = ld; store_in = st;
    e = snap(); ec = ecause_in;
    @(negedge clk);
    check_value({tag, ".busy"}, busy, 0);
    check_value({tag, ".req"}, bus.mem_req, 0);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    check_value({tag, ".valid"}, valid_out, v);
    if (v) begin
      check_value({tag, ".exc"}, exception_out, exc);
      check_value({tag, ".ecause"}, ecause_out, ec);
      check_fields(tag, e);
    end
  endtask

  // Memory slot; plays the memory side with the given grant/response delays.
  task automatic run_mem_op(input bit is_load, input logic [1:0] size, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int gnt_dly,
                            input int rv_dly, input bit err, input string tag);
    fields_t     e;
    logic [3:0]  ec, exp_strb;
    logic [31:0] exp_wdata;
    bit          waits_resp;
    @(posedge clk); #1;
    randomize_fields();
    valid_in = 1'b1; exception_in = 1'b0; load_in = is_load; store_in = !is_load;
    load_signed_in = sgn; load_store_size_in = size;
    alu_data_in = addr; store_data_in = sdata;
    if (is_load) write_select_in = 2'b10;
    e = snap(); ec = ecause_in;
    if (!model_aligned(addr, size)) begin
      @(negedge clk);
      check_value({tag, ".mis_req"}, bus.mem_req, 0);
      check_value({tag, ".mis_busy"}, busy, 0);
      @(posedge clk); #1;
      go_idle();
      @(negedge clk);
      check_value({tag, ".mis_valid"}, valid_out, 1);
      check_value({tag, ".mis_exc"}, exception_out, 1);
      check_value({tag, ".mis_ecause"}, ecause_out, is_load ? 4 : 6);
      check_fields(tag, e);
      return;
    end
    model_store(addr, size, sdata, exp_strb, exp_wdata);
    waits_resp = is_load || c_STORE_WAIT_RESP;
    for (int k = 0; k <= gnt_dly; k++) begin
      @(negedge clk);
      check_value({tag, ".req"}, bus.mem_req, 1);
      check_value({tag, ".addr"}, bus.mem_address, addr - (addr % 4));
      check_value({tag, ".we"}, bus.mem_we, !is_load);
      check_value({tag, ".busy_req"}, busy, 1);
      check_value({tag, ".bubble_req"}, valid_out, 0);
      if (!is_load) begin
        check_value({tag, ".wstrb"}, bus.mem_wstrb, exp_strb);
        check_value({tag, ".wdata"}, bus.mem_wdata, exp_wdata);
      end
      if (k == gnt_dly) begin
        bus.mem_gnt = 1'b1;
`ifdef MEM_ACCESS_FAULT_EN
        bus.mem_error = !waits_resp && err;
`endif
      end
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
`ifdef MEM_ACCESS_FAULT_EN
      bus.mem_error = 1'b0;
`endif
    end
    if (waits_resp) begin
      for (int k = 0; k <= rv_dly; k++) begin
        @(negedge clk);
        check_value({tag, ".req_resp"}, bus.mem_req, 0);
        check_value({tag, ".busy_resp"}, busy, 1);
        check_value({tag, ".bubble_resp"}, valid_out, 0);
        if (k == rv_dly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata;
`ifdef MEM_ACCESS_FAULT_EN
          bus.mem_error  = err;
`endif
        end
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
`ifdef MEM_ACCESS_FAULT_EN
        bus.mem_error  = 1'b0;
`endif
      end
    end
    go_idle();
    @(negedge clk);
    check_value({tag, ".valid"}, valid_out, 1);
    check_value({tag, ".exc"}, exception_out, err);
    check_value({tag, ".ecause"}, ecause_out, err ? (is_load ? 5 : 7) : ec);
    if (is_load)
      check_value({tag, ".ldata"}, load_data_out,
                  err ? 32'd0 : model_load(rdata, addr, size, sgn));
    check_fields(tag, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fields_t     e;
    int          kind;
    bit          err;
    logic [31:0] addr;
    logic [1:0]  size;

    reset = 1'b1; stall = 1'b0; invalidate = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
`ifdef MEM_ACCESS_FAULT_EN
    bus.mem_error = 1'b0;
`endif
    go_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst.valid", valid_out, 0);
    check_value("rst.busy", busy, 0);
    check_value("rst.req", bus.mem_req, 0);
    check_value("rst.pc", pc_out, 0);
    check_value("rst.exc", {exception_out, ecause_out}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset while waiting for rvalid.
    @(posedge clk); #1;
    valid_in = 1; load_in = 1; load_store_size_in = 2'b10; alu_data_in = 32'h100;
    @(negedge clk); bus.mem_gnt = 1'b1;
    @(posedge clk); #1; bus.mem_gnt = 1'b0;
    @(negedge clk);
    check_value("rstresp.busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; go_idle();
    @(negedge clk);
    check_value("rstresp.req", bus.mem_req, 0);
    check_value("rstresp.busy", busy, 0);
    check_value("rstresp.valid", valid_out, 0);

    // ALU add, rd=5, alu_data=0x1234.
    @(posedge clk); #1;
    randomize_fields();
    valid_in = 1; write_select_in = 2'b00; rd_address_in = 5'd5; alu_data_in = 32'h1234;
    @(negedge clk);
    check_value("alu.busy", busy, 0);
    @(posedge clk); #1; go_idle();
    @(negedge clk);
    check_value("alu.busy_after", busy, 0);
    check_value("alu.valid", valid_out, 1);
    check_value("alu.data", alu_data_out, 32'h1234);
    check_value("alu.rd", rd_address_out, 5);

    run_mem_op(1, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_FFFF, 2, 0, 0, "lb");
    check_value("lb.direct", load_data_out, 32'hFFFF_FF80);
    run_mem_op(0, 2'b01, 0, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 0, 0, "sh");
    run_mem_op(1, 2'b10, 0, 32'h3001, 32'h0, 32'h0, 0, 0, 0, "lw_mis");
    run_mem_op(0, 2'b01, 0, 32'h3001, 32'h0, 32'h0, 0, 0, 0, "sh_mis");

    // Flush during RESP: the response is drained and discarded.
    @(posedge clk); #1;
    valid_in = 1; load_in = 1; load_store_size_in = 2'b10; alu_data_in = 32'h4000;
    @(negedge clk); bus.mem_gnt = 1'b1;
    @(posedge clk); #1; bus.mem_gnt = 1'b0; invalidate = 1'b1; go_idle();
    @(negedge clk);
    check_value("inv.busy_flush", busy, 1);
    @(posedge clk); #1; invalidate = 1'b0;
    @(negedge clk);
    check_value("inv.valid_after_flush", valid_out, 0);
    check_value("inv.busy_drain", busy, 1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check_value("inv.busy_done", busy, 0);
    check_value("inv.valid_drop", valid_out, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_value("inv.valid_never", valid_out, 0);

    // Completion under stall is held until stall drops.
    @(posedge clk); #1;
    randomize_fields();
    valid_in = 1; load_in = 1; load_store_size_in = 2'b10; alu_data_in = 32'h5004;
    write_select_in = 2'b10;
    e = snap();
    @(negedge clk); bus.mem_gnt = 1'b1;
    @(posedge clk); #1; bus.mem_gnt = 1'b0; stall = 1'b1;
    @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1122_3344;
    @(posedge clk); #1; bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_value("stall.hold_valid", valid_out, 0);
      check_value("stall.hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    check_value("stall.busy_release", busy, 0);
    @(posedge clk); #1; go_idle();
    @(negedge clk);
    check_value("stall.valid", valid_out, 1);
    check_value("stall.ldata", load_data_out, 32'h1122_3344);
    check_fields("stall", e);

    // Randomized instruction mix.
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      err  = 1'b0;
`ifdef MEM_ACCESS_FAULT_EN
      err  = ($urandom_range(0, 7) == 0);
`endif
      addr = $urandom;
      size = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      case (kind)
        0, 1:    run_plain(1, 0, 0, 0, "r_alu");
        2, 3, 4: run_mem_op(1, size, 1'($urandom), addr, $urandom, $urandom,
                            $urandom_range(0, 3), $urandom_range(0, 3), err, "r_ld");
        5, 6, 7: run_mem_op(0, size, 0, addr, $urandom, $urandom,
                            $urandom_range(0, 3), $urandom_range(0, 3), err, "r_st");
        8:       run_plain(1, 1, 1'($urandom), 1'($urandom), "r_exc");
        default: run_plain(0, 1'($urandom), 0, 0, "r_inv");
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage between execute and writeback.
- Issues data-memory loads and stores over a req/gnt/rvalid bus.
- Aligns and sign-extends load data, flags misaligned accesses as exceptions.
- Registers every control and data field that writeback consumes; the outputs are that pipeline register.

Parameters:
STORE_WAIT_RESP, 0, 1 = a store completes on rvalid instead of on gnt

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
pc_in, next_pc_in, alu_data_in, csr_data_in, store_data_in  input  32 each  from execute; alu_data_in is the address for load/store
write_select_in  input  2  00 alu, 01 csr, 10 load, 11 next_pc
rd_address_in  input  5  destination register
csr_address_in  input  12  CSR address
csr_write_in, mret_in, wfi_in  input  1 each  control passed through
load_in, store_in, load_signed_in  input  1 each  memory op type
load_store_size_in  input  2  00 byte, 01 half, 10 word
valid_in, exception_in  input  1 each  execute slot status
ecause_in  input  4  upstream exception cause
stall  input  1  hazard: hold output register
invalidate  input  1  hazard: trap flush, kill current and incoming
busy  output  1  to hazard: stage cannot accept new input
mem_req, mem_we  output  1 each  bus request, write enable
mem_address  output  32  word-aligned address
mem_wdata  output  32  store data, lane-replicated
mem_wstrb  output  4  byte strobes
mem_gnt, mem_rvalid  input  1 each  grant, read/store response
mem_rdata  input  32  read data
pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out  output  32 each  to writeback
write_select_out, rd_address_out, csr_address_out, csr_write_out, mret_out, wfi_out  output  as inputs  to writeback, registered
valid_out, exception_out  output  1 each  to writeback
ecause_out  output  4  to writeback

Behaviour:
- Reset: all outputs 0, FSM IDLE, mem_req 0, busy 0.
- FSM states: IDLE, REQ (req held, waiting gnt), RESP (waiting rvalid).
- Accepted op: valid_in && !exception_in && (load_in || store_in) && aligned.
- Aligned means: half needs addr[0]=0; word needs addr[1:0]=0.
- Misaligned op: no bus access.
  - Registered as exception_out=1; ecause 4 for a load, 6 for a store.
  - Same 1-cycle latency as ALU instructions.
- IDLE, accepted op, !stall, !invalidate: mem_req=1 combinationally that cycle.
  - gnt same cycle: load (or store when STORE_WAIT_RESP=1) goes to RESP; otherwise the store completes.
  - No gnt: go to REQ.
- REQ: mem_req, address, wdata and wstrb held stable until gnt; never dropped.
- RESP: wait for mem_rvalid; load data is captured that cycle; the op completes.
- busy = 1 in REQ and RESP, and in the IDLE issue cycle until completion.
  - Upstream holds its inputs while busy.
- Output register while an op is pending: valid_out=0 (bubble). On completion it loads all fields with valid_out=1.
- Non-memory instruction: output register loads inputs next cycle (latency 1); valid_out=valid_in.
- stall=1: output register holds and no new request is issued. An in-flight REQ/RESP still proceeds; completion is buffered and presented when stall drops.
- invalidate=1: next cycle valid_out=0.
  - In-flight transaction (REQ/RESP) runs to gnt/rvalid, then is discarded (discard flag) and never reaches writeback.
  - busy stays 1 until the drain finishes.
- Load alignment: byte lane = mem_rdata >> (8*addr[1:0]); half uses addr[1].
  - Zero- or sign-extended per load_signed_in.
- Store: mem_wdata = byte replicated x4, half x2, or word. wstrb: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
- mem_address = {alu_data_in[31:2],2'b00}.
- Exception inputs pass through unchanged, never cause bus traffic. Misaligned check applies only when exception_in=0.

Optional Feature:
MEM_ACCESS_FAULT_EN:
- With it: input mem_error (1) is sampled with rvalid (or with gnt for a store completing on gnt). If set, the op completes with exception_out=1, ecause 5 (load) or 7 (store), and load_data_out=0.
- Without it: no mem_error port; every bus response succeeds.

Test Plan:
1. Reset mid-RESP: reset while waiting rvalid -> next cycle mem_req=0, busy=0, valid_out=0, FSM IDLE.
2. ALU add, rd=5, alu_data=0x1234 -> one cycle later valid_out=1, alu_data_out=0x1234, rd_address_out=5, busy never 1.
3. lb signed at 0x1003, gnt 2 cycles late, rvalid 1 cycle later with rdata=0x80FF_FFFF -> load_data_out=0xFFFFFF80, valid_out=1 the cycle after rvalid.
4. sh at 0x2002, data 0xABCD, immediate gnt -> mem_address=0x2000, wstrb=1100, wdata=0xABCDABCD; valid_out next cycle.
5. lw at 0x3001 -> no mem_req, exception_out=1, ecause_out=4; sh at 0x3001 -> ecause_out=6.
6. invalidate during RESP of lw -> rvalid then accepted, valid_out stays 0, busy drops the cycle after rvalid; stall=1 at completion holds the outputs until stall=0.
